// File: rtl/shared_bus_arbiter_if.sv
// Handshake and status signals between the requesting agents and the bus arbiter.
interface shared_bus_arbiter_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_AGENTS = 4
);
    localparam int unsigned ID_W = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;

    logic [NUM_AGENTS-1:0]       req;
    logic [NUM_AGENTS-1:0]       drive_en;
    logic [NUM_AGENTS*WIDTH-1:0] drive_data;
    logic [NUM_AGENTS-1:0]       gnt;
    logic                        owner_valid;
    logic [ID_W-1:0]             owner_id;
    logic [WIDTH-1:0]            bus_q;
    logic                        contention_err;
    logic                        timeout;

    // Agent side: requests and data out, grant/status in.
    modport master (
        output req, drive_en, drive_data,
        input  gnt, owner_valid, owner_id, bus_q, contention_err, timeout
    );

    // Arbiter side.
    modport slave (
        input  req, drive_en, drive_data,
        output gnt, owner_valid, owner_id, bus_q, contention_err, timeout
    );
endinterface

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with turnaround, hold limit
// and illegal-drive detection. Only the registered owner can reach the bus.
module shared_bus_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_AGENTS = 4,
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned MAX_HOLD   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    shared_bus_arbiter_if.slave   arb,
    inout  wire  [WIDTH-1:0]      bus
);
    localparam int unsigned ID_W   = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;
    localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int unsigned TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_TURN} state_e;

    state_e                state_q, state_d;
    logic [NUM_AGENTS-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]       owner_id_q, owner_id_d;
    logic                  owner_valid_q, owner_valid_d;
    logic [ID_W-1:0]       last_q, last_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [TURN_W-1:0]     turn_q, turn_d;
    logic                  timeout_q, timeout_d;
    logic                  contention_q, contention_d;
    logic [WIDTH-1:0]      bus_q_q;

    logic [ID_W-1:0]       pick_id_c;
    logic                  pick_found_c;
    logic [WIDTH-1:0]      owner_data_c;
    logic                  owner_drive_c;
    logic                  hold_limit_c;
    logic                  owner_req_c;

    // Round-robin search starting just after the last owner.
    always_comb begin
        int unsigned idx;
        pick_found_c = 1'b0;
        pick_id_c    = '0;
        idx          = 0;
        for (int unsigned k = 1; k <= NUM_AGENTS; k++) begin
            idx = (32'(last_q) + k) % NUM_AGENTS;
            if (!pick_found_c && arb.req[ID_W'(idx)]) begin
                pick_found_c = 1'b1;
                pick_id_c    = ID_W'(idx);
            end
        end
    end

    // Select the owner's data word; only the registered owner can drive.
    always_comb begin
        owner_data_c = '0;
        for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
            if (ID_W'(i) == owner_id_q) begin
                owner_data_c = arb.drive_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign owner_drive_c = owner_valid_q && arb.drive_en[owner_id_q];
    assign bus           = owner_drive_c ? owner_data_c : {WIDTH{1'bz}};
    assign owner_req_c   = arb.req[owner_id_q];
    assign hold_limit_c  = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD));

    // Next-state and registered-output logic for the IDLE/OWN/TURN machine.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        owner_id_d    = owner_id_q;
        owner_valid_d = owner_valid_q;
        last_d        = last_q;
        hold_d        = hold_q;
        turn_d        = turn_q;
        timeout_d     = 1'b0;
        contention_d  = |(arb.drive_en & ~gnt_q);

        case (state_q)
            ST_IDLE: begin
                if (pick_found_c) begin
                    gnt_d            = '0;
                    gnt_d[pick_id_c] = 1'b1;
                    owner_id_d       = pick_id_c;
                    owner_valid_d    = 1'b1;
                    hold_d           = HOLD_W'(1);
                    state_d          = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!owner_req_c || hold_limit_c) begin
                    gnt_d         = '0;
                    owner_id_d    = '0;
                    owner_valid_d = 1'b0;
                    last_d        = owner_id_q;
                    timeout_d     = hold_limit_c && owner_req_c;
                    turn_d        = TURN_W'(TURNAROUND);
                    state_d       = ST_TURN;
                end else if (hold_q != {HOLD_W{1'b1}}) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_TURN: begin
                gnt_d = '0;
                if (turn_q <= TURN_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_d = turn_q - TURN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            owner_id_q    <= '0;
            owner_valid_q <= 1'b0;
            last_q        <= ID_W'(NUM_AGENTS - 1);
            hold_q        <= '0;
            turn_q        <= '0;
            timeout_q     <= 1'b0;
            contention_q  <= 1'b0;
            bus_q_q       <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            owner_id_q    <= owner_id_d;
            owner_valid_q <= owner_valid_d;
            last_q        <= last_d;
            hold_q        <= hold_d;
            turn_q        <= turn_d;
            timeout_q     <= timeout_d;
            contention_q  <= contention_d;
            bus_q_q       <= bus;
        end
    end

    assign arb.gnt            = gnt_q;
    assign arb.owner_valid    = owner_valid_q;
    assign arb.owner_id       = owner_id_q;
    assign arb.bus_q          = bus_q_q;
    assign arb.contention_err = contention_q;
    assign arb.timeout        = timeout_q;
endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter (4 agents, MAX_HOLD=4, TURNAROUND=1).
module tb_shared_bus_arbiter;
    localparam int unsigned W  = 32;
    localparam int unsigned NA = 4;
    localparam logic [31:0] PROBE = 32'h5A5A_C3C3;

    logic clk;
    logic rst;
    wire  [W-1:0] bus;
    logic         probe_en;
    logic [W-1:0] probe_val;
    logic [W-1:0] dat [NA];

    int total;
    int bad;

    shared_bus_arbiter_if #(.WIDTH(W), .NUM_AGENTS(NA)) bif ();

    shared_bus_arbiter #(
        .WIDTH(W), .NUM_AGENTS(NA), .TURNAROUND(1), .MAX_HOLD(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (bif.slave),
        .bus (bus)
    );

    // Weak-intent probe driver: bus reads back PROBE only if nobody else drives.
    assign bus = probe_en ? probe_val : {W{1'bz}};
    assign bif.drive_data = {dat[3], dat[2], dat[1], dat[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus must be undriven by the DUT: the probe pattern reads back intact.
    task automatic check_z(input string tag);
        probe_val = PROBE;
        probe_en  = 1'b1;
        #1;
        check_eq(tag, 64'(bus), 64'(PROBE));
        probe_en  = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rr_order [5];
        logic [3:0] exp_gnt;

        total = 0;
        bad   = 0;
        rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        probe_en  = 1'b0;
        probe_val = '0;
        rst = 1'b1;
        bif.req      = '0;
        bif.drive_en = '0;
        for (int i = 0; i < NA; i++) dat[i] = '0;

        // Reset state
        tick();
        tick();
        check_eq("rst_gnt",  64'(bif.gnt), 64'h0);
        check_eq("rst_ov",   64'(bif.owner_valid), 64'h0);
        check_eq("rst_id",   64'(bif.owner_id), 64'h0);
        check_eq("rst_busq", 64'(bif.bus_q), 64'h0);
        check_eq("rst_cerr", 64'(bif.contention_err), 64'h0);
        check_eq("rst_tout", 64'(bif.timeout), 64'h0);
        check_z("rst_busz");
        rst = 1'b0;
        tick();

        // Single owner
        bif.req = 4'b0001;
        tick();
        check_eq("so_gnt", 64'(bif.gnt), 64'h1);
        check_eq("so_ov",  64'(bif.owner_valid), 64'h1);
        check_eq("so_id",  64'(bif.owner_id), 64'h0);
        dat[0] = 32'hA5A5_0001;
        bif.drive_en = 4'b0001;
        #1;
        check_eq("so_bus", 64'(bus), 64'hA5A5_0001);
        tick();
        check_eq("so_busq", 64'(bif.bus_q), 64'hA5A5_0001);
        check_eq("so_cerr", 64'(bif.contention_err), 64'h0);
        bif.req      = 4'b0000;
        bif.drive_en = 4'b0000;
        tick();
        check_eq("so_rel_gnt",  64'(bif.gnt), 64'h0);
        check_eq("so_rel_ov",   64'(bif.owner_valid), 64'h0);
        check_eq("so_rel_tout", 64'(bif.timeout), 64'h0);
        check_z("so_turn_z");
        tick();
        check_eq("so_idle_gnt", 64'(bif.gnt), 64'h0);
        tick();

        // Round-robin from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bif.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_gnt = 4'b0001 << rr_order[n];
            tick();
            check_eq("rr_gnt",  64'(bif.gnt), 64'(exp_gnt));
            check_eq("rr_id",   64'(bif.owner_id), 64'(rr_order[n]));
            tick();
            check_eq("rr_hold", 64'(bif.gnt), 64'(exp_gnt));
            bif.req[rr_order[n]] = 1'b0;
            tick();
            check_eq("rr_turn", 64'(bif.gnt), 64'h0);
            if (n < 4) begin
                bif.req[rr_order[n]] = 1'b1;
                tick();
                check_eq("rr_idle", 64'(bif.gnt), 64'h0);
            end else begin
                bif.req = 4'b0000;
            end
        end
        tick();
        tick();

        // Hold limit: agent 2 forced off after 4 cycles, then agent 3
        bif.req = 4'b1100;
        tick();
        check_eq("hl_g0", 64'(bif.gnt), 64'h4);
        tick();
        tick();
        tick();
        check_eq("hl_g3",   64'(bif.gnt), 64'h4);
        check_eq("hl_t3",   64'(bif.timeout), 64'h0);
        tick();
        check_eq("hl_off",  64'(bif.gnt), 64'h0);
        check_eq("hl_tout", 64'(bif.timeout), 64'h1);
        tick();
        check_eq("hl_tout_clr", 64'(bif.timeout), 64'h0);
        check_eq("hl_gap",      64'(bif.gnt), 64'h0);
        tick();
        check_eq("hl_next", 64'(bif.gnt), 64'h8);
        bif.req = 4'b0000;
        tick();
        check_eq("hl_rel_tout", 64'(bif.timeout), 64'h0);
        tick();

        // Contention: agent 1 owns, agent 3 tries to drive
        bif.req = 4'b0010;
        tick();
        check_eq("ct_gnt", 64'(bif.gnt), 64'h2);
        dat[1] = 32'h1111_2222;
        dat[3] = 32'hDEAD_BEEF;
        bif.drive_en = 4'b1010;
        #1;
        check_eq("ct_bus0", 64'(bus), 64'h1111_2222);
        tick();
        check_eq("ct_cerr", 64'(bif.contention_err), 64'h1);
        check_eq("ct_bus1", 64'(bus), 64'h1111_2222);
        check_eq("ct_busq", 64'(bif.bus_q), 64'h1111_2222);
        bif.drive_en = 4'b0010;
        tick();
        check_eq("ct_cerr_clr", 64'(bif.contention_err), 64'h0);
        check_eq("ct_bus2",     64'(bus), 64'h1111_2222);
        bif.req      = 4'b0000;
        bif.drive_en = 4'b0000;
        tick();
        tick();

        // Owner granted but not driving
        bif.req = 4'b0001;
        tick();
        check_eq("nd_gnt", 64'(bif.gnt), 64'h1);
        check_z("nd_busz");
        dat[0] = 32'hA5A5_0001;
        bif.drive_en = 4'b0001;
        #1;
        check_eq("nd_bus", 64'(bus), 64'hA5A5_0001);
        bif.req      = 4'b0000;
        bif.drive_en = 4'b0000;
        tick();
        tick();
        tick();

        // Reset while agent 2 owns and drives
        bif.req = 4'b0100;
        tick();
        check_eq("rm_gnt", 64'(bif.gnt), 64'h4);
        dat[2] = 32'hC0DE_0002;
        bif.drive_en = 4'b0100;
        #1;
        check_eq("rm_bus", 64'(bus), 64'hC0DE_0002);
        rst = 1'b1;
        bif.req = 4'b1111;
        tick();
        check_eq("rm_gnt0", 64'(bif.gnt), 64'h0);
        check_eq("rm_ov0",  64'(bif.owner_valid), 64'h0);
        check_z("rm_busz");
        bif.drive_en = 4'b0000;
        rst = 1'b0;
        tick();
        check_eq("rm_first", 64'(bif.gnt), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shared_bus_arbiter.md
Name: shared_bus_arbiter

Overview:
- Parametrised owner of one shared tri-state bus with NUM_AGENTS requesting agents.
- Grants ownership round-robin and drives the bus only from the current owner; all other times the bus is high-impedance.
- Inserts mandatory turnaround (all-Z) cycles between owners, bounds the hold time per owner, and flags illegal drive attempts.
- Sits between the PCI-side agents and the shared AD-style bus, so multi-driver X conflicts cannot occur by construction.

Parameters:
WIDTH, 32, bus width in bits
NUM_AGENTS, 4, number of requesting agents (2..16)
TURNAROUND, 1, all-Z idle cycles inserted after every ownership (min 1)
MAX_HOLD, 16, max consecutive OWN cycles per grant; 0 = unlimited

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
req  in  NUM_AGENTS  per-agent bus request, level
drive_en  in  NUM_AGENTS  per-agent request to place data on the bus this cycle
drive_data  in  NUM_AGENTS*WIDTH  agent i data at bits [i*WIDTH +: WIDTH]
gnt  out  NUM_AGENTS  one-hot registered grant
owner_valid  out  1  high while a grant is held
owner_id  out  clog2(NUM_AGENTS)  index of current owner; 0 when none
bus  inout  WIDTH  shared tri-state bus
bus_q  out  WIDTH  bus value registered every clock
contention_err  out  1  one-cycle pulse: drive_en from a non-owner
timeout  out  1  one-cycle pulse: owner forced off by MAX_HOLD

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state=IDLE; gnt=0; owner_valid=0; owner_id=0; bus_q=0; contention_err=0; timeout=0.
  - Round-robin pointer last=NUM_AGENTS-1, so agent 0 has first priority.
  - Bus is Z during and after reset.
  - Reset mid-ownership drops gnt at that edge; there is no turnaround after reset.
- FSM states: IDLE, OWN, TURN.
- IDLE:
  - If any req is high at an edge, pick the first requester searching last+1, last+2, … modulo NUM_AGENTS.
  - At that edge: gnt one-hot, owner_id set, owner_valid=1, hold counter=1, state=OWN.
  - Latency is 1 clock from req sampled high to gnt high.
- OWN:
  - Bus = drive_data[owner] when drive_en[owner]=1, else Z. This is combinational from registered gnt.
  - Exit to TURN when req[owner]=0 at an edge, or when MAX_HOLD!=0 and the hold counter = MAX_HOLD.
  - On exit: gnt=0, owner_valid=0, owner_id=0, last=owner; timeout pulses if the exit was the hold limit while req[owner] was still 1.
  - Otherwise the hold counter increments, saturating.
- TURN:
  - Bus Z; gnt=0.
  - Lasts exactly TURNAROUND cycles, counted by a down-counter; then state=IDLE.
  - Requests are evaluated in the next IDLE cycle, so the minimum gap between owners is TURNAROUND+1 cycles.
  - A forced-off owner that still requests competes normally; round-robin gives the other requesters priority first.
- contention_err:
  - Registered.
  - Set for the cycle after any edge where drive_en[i]=1 with i != owner_id or owner_valid=0.
  - The offending agent is never driven onto the bus.
- bus_q: registered copy of bus every edge. Sampling a Z bus yields Z/X in simulation; the bench only checks it when the bus is owned.
- Simultaneous events:
  - req drops on the same edge as the hold limit: normal release, no timeout.
  - A new requester arriving during TURN waits for IDLE.
- Widths: the hold counter is clog2(MAX_HOLD+1) bits.
- No combinational path from req to gnt.

Test Plan:
- Single owner:
  - Reset, then req=4'b0001 with drive_en[0]=1 and data0=32'hA5A5_0001.
  - Required: gnt=0001 one cycle later; bus and next-cycle bus_q = A5A5_0001.
  - Dropping req gives gnt=0, then 1 Z cycle, then IDLE.
- Round-robin:
  - req=4'b1111 held; each owner releases after 2 cycles.
  - Required grant order: 0, 1, 2, 3, 0.
  - Every owner change is separated by TURNAROUND Z cycles plus 1 IDLE cycle.
- Hold limit:
  - MAX_HOLD=4, agent 2 holds req continuously, agent 3 also requests.
  - Required: gnt[2] for exactly 4 cycles, then a timeout pulse, then turnaround, then gnt[3].
- Contention:
  - Agent 1 owns; agent 3 asserts drive_en with data 32'hDEAD_BEEF.
  - Required: contention_err=1 the next cycle; bus keeps agent 1 data and never shows DEAD_BEEF or X.
- Owner not driving:
  - Agent 0 granted with drive_en[0]=0.
  - Required: bus=Z for all WIDTH bits.
  - Setting drive_en[0]=1 puts the data on the bus the same cycle.
- Reset mid-operation:
  - rst=1 while agent 2 owns and drives.
  - Required: gnt=0 and bus Z after that edge; with all req high after reset, agent 0 is granted first.
